// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC register, credit-limited word fetches, in-order
// instruction FIFO to decode, redirect flush with stale-response drain. Option: FETCH_PERF_EN.
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter int          CNT_W     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W:0]   CRED_C  = (CNT_W+1)'(BUF_DEPTH);

    typedef enum logic {FETCH, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  occ_q, occ_d, out_q, out_d, stale_q, stale_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [31:0]       instr_q [BUF_DEPTH];
    logic [31:0]       pcp4_q  [BUF_DEPTH];
    logic              rvalid, req, push, pop;
    logic [CNT_W:0]    credit_used;
    logic              unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc_i[1:0];
    assign rvalid        = imem_rvalid_i & ~rst_i;
    assign credit_used   = {1'b0, occ_q} + {1'b0, out_q};
    assign req           = (state_q == FETCH) & ~redirect_i & ~rst_i & (credit_used < CRED_C);
    assign push          = (state_q == FETCH) & rvalid & ~redirect_i;
    assign instr_valid_o = (state_q == FETCH) & (occ_q != '0);
    assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;
    // Outputs come straight from FIFO storage, never from imem_rdata_i.
    assign instr_o     = instr_q[rd_ptr_q];
    assign pc_plus4_o  = pcp4_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        occ_d     = occ_q;
        out_d     = out_q;
        stale_d   = stale_q;
        if (redirect_i) begin
            // A response landing in the redirect cycle is already stale.
            pc_d      = {redirect_pc_i[31:2], 2'b00};
            resp_pc_d = {redirect_pc_i[31:2], 2'b00};
            occ_d     = '0;
            out_d     = out_q - CNT_W'(rvalid);
            stale_d   = out_q - CNT_W'(rvalid);
            state_d   = (stale_d != '0) ? DRAIN : FETCH;
        end else if (state_q == DRAIN) begin
            if (rvalid) begin
                out_d   = out_q - CNT_W'(1);
                stale_d = stale_q - CNT_W'(1);
                if (stale_q == CNT_W'(1))
                    state_d = FETCH;
            end
        end else begin
            if (req)
                pc_d = pc_q + 32'd4;
            if (push)
                resp_pc_d = resp_pc_q + 32'd4;
            out_d = out_q + CNT_W'(req) - CNT_W'(rvalid);
            occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FETCH;
            pc_q      <= PC_RESET;
            resp_pc_q <= PC_RESET;
            occ_q     <= '0;
            out_q     <= '0;
            stale_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                instr_q[i] <= '0;
                pcp4_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            occ_q     <= occ_d;
            out_q     <= out_d;
            stale_q   <= stale_d;
            if (redirect_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    instr_q[wr_ptr_q] <= imem_rdata_i;
                    pcp4_q[wr_ptr_q]  <= resp_pc_q + 32'd4;
                    wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push && !pop)
            assert (occ_q != DEPTH_C);
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop && fetch_cnt_q != '1)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (redirect_i && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirect/drain,
// PC wrap (second instance) and mid-operation reset.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, rvalid, valid, ready, redir;
    logic [31:0] addr, rdata, instr, pcp4, redir_pc;
    logic        req2, rvalid2, valid2;
    logic [31:0] addr2, rdata2, instr2, pcp42;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, fetch_cnt2;
    logic [15:0] flush_cnt, flush_cnt2;
`endif

    int checks = 0;
    int fails  = 0;
    int lat    = 1;

    instr_fetch_unit #(.PC_RESET(32'h0000_0000), .BUF_DEPTH(2), .CNT_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .imem_req_o(req), .imem_addr_o(addr),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .instr_o(instr),
        .pc_plus4_o(pcp4), .instr_valid_o(valid), .instr_ready_i(ready),
        .redirect_i(redir), .redirect_pc_i(redir_pc)
`ifdef FETCH_PERF_EN
        , .fetch_cnt_o(fetch_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

    instr_fetch_unit #(.PC_RESET(32'hFFFF_FFF8), .BUF_DEPTH(2), .CNT_W(3)) dut_w (
        .clk_i(clk), .rst_i(rst), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2), .instr_o(instr2),
        .pc_plus4_o(pcp42), .instr_valid_o(valid2), .instr_ready_i(1'b1),
        .redirect_i(1'b0), .redirect_pc_i(32'h0)
`ifdef FETCH_PERF_EN
        , .fetch_cnt_o(fetch_cnt2), .flush_cnt_o(flush_cnt2)
`endif
    );

    // Memory model: fixed latency pipeline, data word = its own address.
    logic        mq_v [8];
    logic [31:0] mq_a [8];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) mq_v[k] <= 1'b0;
        end else begin
            for (int k = 0; k < 7; k++) begin
                mq_v[k] <= mq_v[k+1];
                mq_a[k] <= mq_a[k+1];
            end
            mq_v[7] <= 1'b0;
            if (req) begin
                mq_v[lat-1] <= 1'b1;
                mq_a[lat-1] <= addr;
            end
        end
    end
    assign rvalid = mq_v[0];
    assign rdata  = mq_a[0];

    always @(posedge clk) begin
        rvalid2 <= rst ? 1'b0 : req2;
        rdata2  <= addr2;
    end

    logic        wrap_rec = 1'b0;
    logic [31:0] wq_a[$], wq_p[$], wq_i[$];
    always @(negedge clk) begin
        if (wrap_rec && !rst) begin
            if (req2 && wq_a.size() < 3) wq_a.push_back(addr2);
            if (valid2 && wq_p.size() < 3) begin
                wq_p.push_back(pcp42);
                wq_i.push_back(instr2);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Returns at posedge+1 of the first cycle with rst low (cycle C0).
    task automatic do_reset();
        rst = 1'b1; redir = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
        tick(); tick();
        @(negedge clk);
        checks++; if (req !== 1'b0) begin fails++; $display("FAIL reset_req got %0h want 0", req); end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0h want 0", valid); end
        checks++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %0h want 0", instr); end
        checks++; if (pcp4 !== 32'h0) begin fails++; $display("FAIL reset_pcp4 got %0h want 0", pcp4); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        int npop;
        lat = 1; ready = 1'b1;
        do_reset();
        @(negedge clk); // C0
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL stream_c0_req got %0h/%0h want 1/0", req, addr); end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL stream_c0_valid got %0h want 0", valid); end
        tick(); @(negedge clk); // C1
        checks++; if (req !== 1'b1 || addr !== 32'h4) begin fails++; $display("FAIL stream_c1_req got %0h/%0h want 1/4", req, addr); end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL stream_c1_valid got %0h want 0", valid); end
        tick(); @(negedge clk); // C2
        checks++; if (valid !== 1'b1 || instr !== 32'h0 || pcp4 !== 32'h4) begin fails++; $display("FAIL stream_c2_head got %0h/%0h/%0h want 1/0/4", valid, instr, pcp4); end
        checks++; if (req !== 1'b0) begin fails++; $display("FAIL stream_c2_credit got %0h want 0", req); end
        tick(); @(negedge clk); // C3
        checks++; if (valid !== 1'b1 || instr !== 32'h4 || pcp4 !== 32'h8) begin fails++; $display("FAIL stream_c3_head got %0h/%0h/%0h want 1/4/8", valid, instr, pcp4); end
        checks++; if (req !== 1'b1 || addr !== 32'h8) begin fails++; $display("FAIL stream_c3_req got %0h/%0h want 1/8", req, addr); end
        tick(); @(negedge clk); // C4 bubble
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL stream_c4_bubble got %0h want 0", valid); end
        tick(); @(negedge clk); // C5
        checks++; if (valid !== 1'b1 || instr !== 32'h8 || pcp4 !== 32'hC) begin fails++; $display("FAIL stream_c5_head got %0h/%0h/%0h want 1/8/c", valid, instr, pcp4); end
        exp = 32'hC; npop = 0;
        for (int i = 0; i < 12; i++) begin
            tick(); @(negedge clk);
            if (valid) begin
                checks++; if (instr !== exp || pcp4 !== exp + 32'd4) begin fails++; $display("FAIL stream_seq got %0h/%0h want %0h/%0h", instr, pcp4, exp, exp + 32'd4); end
                exp = exp + 32'd4; npop++;
            end
        end
        checks++; if (npop != 8) begin fails++; $display("FAIL stream_rate got %0d pops want 8", npop); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        int npop;
        lat = 1; ready = 1'b0;
        do_reset();
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL bp_c0_req got %0h/%0h want 1/0", req, addr); end
        tick(); @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h4) begin fails++; $display("FAIL bp_c1_req got %0h/%0h want 1/4", req, addr); end
        tick(); @(negedge clk);
        checks++; if (req !== 1'b0) begin fails++; $display("FAIL bp_c2_credit got %0h want 0", req); end
        for (int i = 0; i < 7; i++) tick();
        @(negedge clk); // C9
        checks++; if (valid !== 1'b1 || instr !== 32'h0 || req !== 1'b0) begin fails++; $display("FAIL bp_hold got %0h/%0h/%0h want 1/0/0", valid, instr, req); end
        tick(); ready = 1'b1; // C10
        exp = 32'h0; npop = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid) begin
                checks++; if (instr !== exp || pcp4 !== exp + 32'd4) begin fails++; $display("FAIL bp_seq got %0h/%0h want %0h/%0h", instr, pcp4, exp, exp + 32'd4); end
                exp = exp + 32'd4; npop++;
            end
            tick();
        end
        checks++; if (npop != 4) begin fails++; $display("FAIL bp_release got %0d pops want 4", npop); end
    endtask

    task automatic test_redirect();
        int got, wcyc;
        lat = 3; ready = 1'b0;
        do_reset();
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL rd_c0_req got %0h/%0h want 1/0", req, addr); end
        tick(); @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h4) begin fails++; $display("FAIL rd_c1_req got %0h/%0h want 1/4", req, addr); end
        tick(); redir = 1'b1; redir_pc = 32'h0000_0103; // C2
        @(negedge clk);
        checks++; if (req !== 1'b0) begin fails++; $display("FAIL rd_c2_noreq got %0h want 0", req); end
        tick(); redir = 1'b0; ready = 1'b1; // C3
        @(negedge clk);
        checks++; if (req !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL rd_drain1 got %0h/%0h want 0/0", req, valid); end
        tick(); @(negedge clk); // C4
        checks++; if (req !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL rd_drain2 got %0h/%0h want 0/0", req, valid); end
        tick(); @(negedge clk); // C5
        checks++; if (req !== 1'b1 || addr !== 32'h100) begin fails++; $display("FAIL rd_refetch got %0h/%0h want 1/100", req, addr); end
        got = 0; wcyc = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            tick(); @(negedge clk);
            if (valid) begin got = 1; wcyc = i + 1; end
        end
        checks++; if (got != 1 || wcyc != 4) begin fails++; $display("FAIL rd_first_valid got %0d/%0d want 1/4", got, wcyc); end
        checks++; if (instr !== 32'h100 || pcp4 !== 32'h104) begin fails++; $display("FAIL rd_first_word got %0h/%0h want 100/104", instr, pcp4); end
    endtask

    task automatic test_redirect_coincident();
        int got, wcyc;
        lat = 2; ready = 1'b1;
        do_reset();
        tick(); @(negedge clk); // C1
        checks++; if (req !== 1'b1 || addr !== 32'h4) begin fails++; $display("FAIL co_c1_req got %0h/%0h want 1/4", req, addr); end
        tick(); @(negedge clk); // C2
        checks++; if (req !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL co_c2 got %0h/%0h want 0/0", req, valid); end
        tick(); // C3: head valid and a response arriving
        checks++; if (valid !== 1'b1 || rvalid !== 1'b1 || instr !== 32'h0) begin fails++; $display("FAIL co_setup got %0h/%0h/%0h want 1/1/0", valid, rvalid, instr); end
        redir = 1'b1; redir_pc = 32'h0000_0200;
        @(negedge clk);
        checks++; if (req !== 1'b0) begin fails++; $display("FAIL co_noreq got %0h want 0", req); end
        tick(); redir = 1'b0; // C4
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL co_flushed got %0h want 0", valid); end
        checks++; if (req !== 1'b1 || addr !== 32'h200) begin fails++; $display("FAIL co_nodrain got %0h/%0h want 1/200", req, addr); end
        got = 0; wcyc = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            tick(); @(negedge clk);
            if (valid) begin got = 1; wcyc = i + 1; end
        end
        checks++; if (got != 1 || wcyc != 3) begin fails++; $display("FAIL co_first_valid got %0d/%0d want 1/3", got, wcyc); end
        checks++; if (instr !== 32'h200 || pcp4 !== 32'h204) begin fails++; $display("FAIL co_first_word got %0h/%0h want 200/204", instr, pcp4); end
    endtask

    task automatic test_wrap();
        logic [31:0] ea [3];
        logic [31:0] ep [3];
        ea = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        ep = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        wq_a.delete(); wq_p.delete(); wq_i.delete();
        do_reset();
        wrap_rec = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        wrap_rec = 1'b0;
        checks++; if (wq_a.size() != 3 || wq_p.size() != 3) begin fails++; $display("FAIL wrap_count got %0d/%0d want 3/3", wq_a.size(), wq_p.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (wq_a[i] !== ea[i]) begin fails++; $display("FAIL wrap_addr%0d got %0h want %0h", i, wq_a[i], ea[i]); end
                checks++; if (wq_p[i] !== ep[i]) begin fails++; $display("FAIL wrap_pcp4_%0d got %0h want %0h", i, wq_p[i], ep[i]); end
                checks++; if (wq_i[i] !== ea[i]) begin fails++; $display("FAIL wrap_instr%0d got %0h want %0h", i, wq_i[i], ea[i]); end
            end
        end
    endtask

    task automatic test_mid_reset();
        int npop;
        lat = 1; ready = 1'b1;
        do_reset();
        npop = 0;
        for (int i = 0; i < 20 && npop < 5; i++) begin
            @(negedge clk);
            if (valid && ready) npop++;
            if (npop < 5) tick();
        end
        checks++; if (npop != 5) begin fails++; $display("FAIL mr_pops got %0d want 5", npop); end
        tick(); redir = 1'b1; redir_pc = 32'h0000_0040;
        tick(); redir = 1'b0; ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        @(negedge clk);
        checks++; if (valid !== 1'b1 || req !== 1'b0 || instr !== 32'h40) begin fails++; $display("FAIL mr_full got %0h/%0h/%0h want 1/0/40", valid, req, instr); end
`ifdef FETCH_PERF_EN
        checks++; if (fetch_cnt !== 32'd5 || flush_cnt !== 16'd1) begin fails++; $display("FAIL mr_counters got %0d/%0d want 5/1", fetch_cnt, flush_cnt); end
`endif
        rst = 1'b1;
        tick(); @(negedge clk);
        checks++; if (valid !== 1'b0 || req !== 1'b0) begin fails++; $display("FAIL mr_reset_out got %0h/%0h want 0/0", valid, req); end
        checks++; if (instr !== 32'h0 || pcp4 !== 32'h0) begin fails++; $display("FAIL mr_reset_data got %0h/%0h want 0/0", instr, pcp4); end
`ifdef FETCH_PERF_EN
        checks++; if (fetch_cnt !== 32'd0 || flush_cnt !== 16'd0) begin fails++; $display("FAIL mr_counters_clr got %0d/%0d want 0/0", fetch_cnt, flush_cnt); end
`endif
        tick(); rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL mr_restart got %0h/%0h want 1/0", req, addr); end
        tick(); tick(); @(negedge clk);
        checks++; if (valid !== 1'b1 || instr !== 32'h0 || pcp4 !== 32'h4) begin fails++; $display("FAIL mr_first got %0h/%0h/%0h want 1/0/4", valid, instr, pcp4); end
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_coincident();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
